// File: rtl/call_observer_pkg.sv
// Shared types and constants for the call/return observer: OR1K opcodes, event kinds,
// FSM states and the FIFO entry layout.
package call_observer_pkg;

  localparam logic [5:0] OpJal  = 6'h01;
  localparam logic [5:0] OpJalr = 6'h12;
  localparam logic [5:0] OpJr   = 6'h11;

  typedef enum logic {
    KindCall = 1'b0,
    KindRet  = 1'b1
  } kind_e;

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] addr;
  } event_t;

  localparam int unsigned EventW = $bits(event_t);

  function automatic logic is_call_op(input logic [5:0] op);
    return (op == OpJal) || (op == OpJalr);
  endfunction

endpackage

// File: rtl/call_observer_if.sv
// Retire-stream inputs and monitor-facing outputs of the call observer.
interface call_observer_if;

  logic        insn_valid_i;
  logic [31:0] insn_i;
  logic [31:0] pc_i;
  logic [31:0] rb_value_i;
  logic        flush_i;
  logic        monitor_busy_i;
  logic        monitor_jal_o;
  logic        monitor_jr_o;
  logic [31:0] monitor_address_o;
  logic        overflow_o;

  // Core/monitor environment side.
  modport master (
    output insn_valid_i, insn_i, pc_i, rb_value_i, flush_i, monitor_busy_i,
    input  monitor_jal_o, monitor_jr_o, monitor_address_o, overflow_o
  );

  // Observer side.
  modport slave (
    input  insn_valid_i, insn_i, pc_i, rb_value_i, flush_i, monitor_busy_i,
    output monitor_jal_o, monitor_jr_o, monitor_address_o, overflow_o
  );

endinterface

// File: rtl/call_observer_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module call_observer_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset; contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/call_observer.sv
// Decodes OR1K calls/returns from the retire stream, confirms them once the delay slot
// retires unflushed, queues them and emits paced single-cycle pulses to the monitor.
module call_observer
  import call_observer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RET_REG    = 9,
  parameter int unsigned EMIT_GAP   = 2
) (
  input logic            clk,
  input logic            reset,
  call_observer_if.slave bus
);

  localparam logic [4:0]  RetRegIdx = 5'(RET_REG);
  localparam int unsigned GapW      = (EMIT_GAP > 1) ? $clog2(EMIT_GAP) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(EMIT_GAP - 1);

  state_e          state_q;
  event_t          pend_q;
  event_t          cand;
  event_t          fifo_dout;
  logic            is_call, is_ret, cand_valid;
  logic            push, pop_fire, fifo_full, fifo_empty;
  logic [GapW-1:0] gap_q;
  logic            jal_q, jr_q, overflow_q;
  logic [31:0]     addr_q;
  logic            unused_insn_bits;

  assign unused_insn_bits = ^{bus.insn_i[25:16], bus.insn_i[10:0]};

  // Decode
  assign is_call    = is_call_op(bus.insn_i[31:26]);
  assign is_ret     = (bus.insn_i[31:26] == OpJr) && (bus.insn_i[15:11] == RetRegIdx);
  assign cand_valid = bus.insn_valid_i && !bus.flush_i && (is_call || is_ret);

  always_comb begin
    cand.kind = is_call ? KindCall : KindRet;
    cand.addr = is_call ? (bus.pc_i + 32'd8) : bus.rb_value_i;
  end

  // Candidate FSM; the delay-slot instruction is consumed in StPend and never decoded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cand_valid) begin
            state_q <= StPend;
            pend_q  <= cand;
          end
        end
        StPend: begin
          if (bus.flush_i || bus.insn_valid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push     = (state_q == StPend) && bus.insn_valid_i && !bus.flush_i;
  assign pop_fire = !fifo_empty && !bus.monitor_busy_i && (gap_q == '0);

  call_observer_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EventW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop_fire),
    .din   (pend_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Emission, pacing and overflow; the gap covers the monitor's late busy assertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jal_q      <= 1'b0;
      jr_q       <= 1'b0;
      addr_q     <= '0;
      gap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      jal_q <= pop_fire && (fifo_dout.kind == KindCall);
      jr_q  <= pop_fire && (fifo_dout.kind == KindRet);
      if (pop_fire) begin
        addr_q <= fifo_dout.addr;
        gap_q  <= GapLoad;
      end else if (gap_q != '0) begin
        gap_q  <= gap_q - 1'b1;
      end
      if (push && fifo_full && !pop_fire) overflow_q <= 1'b1;
    end
  end

  assign bus.monitor_jal_o     = jal_q;
  assign bus.monitor_jr_o      = jr_q;
  assign bus.monitor_address_o = addr_q;
  assign bus.overflow_o        = overflow_q;

endmodule

// File: tb/tb_call_observer.sv
// Self-checking bench for call_observer: directed vector table, corner-case sequences
// and randomized traffic against a queue-based reference model.
module tb_call_observer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;

  localparam logic [31:0] JAL  = 32'h0400_0000;
  localparam logic [31:0] JALR = 32'h4800_0000;
  localparam logic [31:0] JR9  = 32'h4400_4800;
  localparam logic [31:0] JR3  = 32'h4400_1800;
  localparam logic [31:0] NOP  = 32'h1500_0000;

  logic clk = 1'b0;
  logic reset;

  call_observer_if bus ();

  call_observer #(
    .FIFO_DEPTH (DEPTH),
    .RET_REG    (9),
    .EMIT_GAP   (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct {
    bit          kind;
    logic [31:0] addr;
  } ev_t;

  ev_t         mq[$];
  bit          m_pend;
  ev_t         m_cand;
  int          cyc;
  int          last_pop;
  bit          exp_jal, exp_jr, exp_ovf;
  logic [31:0] exp_addr;

  typedef struct {
    bit          v;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] rb;
    bit          fl;
    bit          jal;
    bit          jr;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend   = 0;
    cyc      = 0;
    last_pop = -1000;
    exp_jal  = 0;
    exp_jr   = 0;
    exp_ovf  = 0;
    exp_addr = '0;
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic run_cycle(input bit v, input logic [31:0] insn, input logic [31:0] pc,
                           input logic [31:0] rb, input bit fl, input bit busy);
    bit  pop;
    ev_t e;
    bus.insn_valid_i   = v;
    bus.insn_i         = insn;
    bus.pc_i           = pc;
    bus.rb_value_i     = rb;
    bus.flush_i        = fl;
    bus.monitor_busy_i = busy;

    pop     = (mq.size() > 0) && !busy && (cyc - last_pop >= int'(GAP));
    exp_jal = 0;
    exp_jr  = 0;
    if (pop) begin
      e        = mq.pop_front();
      exp_jal  = (e.kind == 1'b0);
      exp_jr   = (e.kind == 1'b1);
      exp_addr = e.addr;
      last_pop = cyc;
    end
    if (m_pend) begin
      if (v && !fl) begin
        if (mq.size() < DEPTH) mq.push_back(m_cand);
        else exp_ovf = 1;
      end
      if (v || fl) m_pend = 0;
    end else if (v && !fl) begin
      if (insn[31:26] == 6'h01 || insn[31:26] == 6'h12) begin
        m_pend = 1;
        m_cand = '{kind: 1'b0, addr: pc + 32'd8};
      end else if (insn[31:26] == 6'h11 && insn[15:11] == 5'd9) begin
        m_pend = 1;
        m_cand = '{kind: 1'b1, addr: rb};
      end
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("jal_o", {31'd0, bus.monitor_jal_o}, {31'd0, exp_jal});
    chk("jr_o", {31'd0, bus.monitor_jr_o}, {31'd0, exp_jr});
    chk("address_o", bus.monitor_address_o, exp_addr);
    chk("overflow_o", {31'd0, bus.overflow_o}, {31'd0, exp_ovf});
  endtask

  task automatic idle(input int n, input bit busy);
    for (int i = 0; i < n; i++) run_cycle(0, NOP, 32'h0, 32'h0, 0, busy);
  endtask

  task automatic do_call(input logic [31:0] pc, input bit busy);
    run_cycle(1, JAL, pc, 32'h0, 0, busy);
    run_cycle(1, NOP, pc + 32'd4, 32'h0, 0, busy);
  endtask

  task automatic apply_reset();
    bus.insn_valid_i = 0;
    bus.flush_i      = 0;
    reset            = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  // Count pulses over n idle cycles and check their order and spacing.
  task automatic drain_check(input string name, input int n, input int exp_cnt,
                             input logic [31:0] exp_addrs[4]);
    logic [31:0] got[$];
    int          at[$];
    for (int i = 0; i < n; i++) begin
      run_cycle(0, NOP, 32'h0, 32'h0, 0, 0);
      if (bus.monitor_jal_o || bus.monitor_jr_o) begin
        got.push_back(bus.monitor_address_o);
        at.push_back(cyc);
      end
    end
    chk({name, "_count"}, got.size(), exp_cnt);
    for (int i = 0; i < got.size() && i < 4; i++) chk({name, "_order"}, got[i], exp_addrs[i]);
    for (int i = 1; i < at.size(); i++) begin
      checks++;
      if (at[i] - at[i-1] < int'(GAP)) begin
        errors++;
        $display("FAIL %s_spacing: got %0d cycles expected >= %0d", name, at[i] - at[i-1], GAP);
      end
    end
  endtask

  initial begin
    logic [31:0] exp4[4];
    logic [31:0] r, insn, pcv, rbv;
    int          pick;

    bus.insn_valid_i   = 0;
    bus.insn_i         = '0;
    bus.pc_i           = '0;
    bus.rb_value_i     = '0;
    bus.flush_i        = 0;
    bus.monitor_busy_i = 0;
    reset              = 1;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_jal", {31'd0, bus.monitor_jal_o}, 32'd0);
    chk("reset_jr", {31'd0, bus.monitor_jr_o}, 32'd0);
    chk("reset_addr", bus.monitor_address_o, 32'd0);
    chk("reset_ovf", {31'd0, bus.overflow_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;

    // Directed vectors: call, return r9, return r3, flushed call, jalr, branch in delay slot
    tbl[0]  = '{1, JAL,  32'h1000, 32'h0,    0, 0, 0, 32'h0};
    tbl[1]  = '{1, NOP,  32'h1004, 32'h0,    0, 0, 0, 32'h0};
    tbl[2]  = '{0, NOP,  32'h0,    32'h0,    0, 1, 0, 32'h1008};
    tbl[3]  = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[4]  = '{1, JR9,  32'h2000, 32'h1008, 0, 0, 0, 32'h1008};
    tbl[5]  = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[6]  = '{1, NOP,  32'h2004, 32'h0,    0, 0, 0, 32'h1008};
    tbl[7]  = '{0, NOP,  32'h0,    32'h0,    0, 0, 1, 32'h1008};
    tbl[8]  = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[9]  = '{1, JR3,  32'h2100, 32'hdead, 0, 0, 0, 32'h1008};
    tbl[10] = '{1, NOP,  32'h2104, 32'h0,    0, 0, 0, 32'h1008};
    tbl[11] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[12] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[13] = '{1, JAL,  32'h2000, 32'h0,    0, 0, 0, 32'h1008};
    tbl[14] = '{1, NOP,  32'h2004, 32'h0,    1, 0, 0, 32'h1008};
    tbl[15] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[16] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h1008};
    tbl[17] = '{1, JALR, 32'h3000, 32'h0,    0, 0, 0, 32'h1008};
    tbl[18] = '{1, NOP,  32'h3004, 32'h0,    0, 0, 0, 32'h1008};
    tbl[19] = '{0, NOP,  32'h0,    32'h0,    0, 1, 0, 32'h3008};
    tbl[20] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h3008};
    tbl[21] = '{1, JAL,  32'h4000, 32'h0,    0, 0, 0, 32'h3008};
    tbl[22] = '{1, JAL,  32'h4004, 32'h0,    0, 0, 0, 32'h3008};
    tbl[23] = '{0, NOP,  32'h0,    32'h0,    0, 1, 0, 32'h4008};
    tbl[24] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h4008};
    tbl[25] = '{0, NOP,  32'h0,    32'h0,    0, 0, 0, 32'h4008};

    for (int i = 0; i < 26; i++) begin
      run_cycle(tbl[i].v, tbl[i].insn, tbl[i].pc, tbl[i].rb, tbl[i].fl, 0);
      chk($sformatf("vec%0d_jal", i), {31'd0, bus.monitor_jal_o}, {31'd0, tbl[i].jal});
      chk($sformatf("vec%0d_jr", i), {31'd0, bus.monitor_jr_o}, {31'd0, tbl[i].jr});
      chk($sformatf("vec%0d_addr", i), bus.monitor_address_o, tbl[i].addr);
    end

    // Five calls confirmed while busy: one is dropped, four drain in order
    apply_reset();
    for (int i = 1; i <= 5; i++) do_call(32'(i) * 32'h100, 1);
    chk("ovf_set", {31'd0, bus.overflow_o}, 32'd1);
    exp4 = '{32'h108, 32'h208, 32'h308, 32'h408};
    drain_check("ovf_drain", 12, 4, exp4);
    chk("ovf_sticky", {31'd0, bus.overflow_o}, 32'd1);

    // Full FIFO with simultaneous push and pop: no drop, occupancy stays at four
    apply_reset();
    for (int i = 1; i <= 4; i++) do_call(32'(i) * 32'h100, 1);
    run_cycle(1, JAL, 32'h900, 32'h0, 0, 1);
    run_cycle(1, NOP, 32'h904, 32'h0, 0, 0);
    chk("pushpop_ovf", {31'd0, bus.overflow_o}, 32'd0);
    idle(3, 1);
    exp4 = '{32'h208, 32'h308, 32'h408, 32'h908};
    drain_check("pushpop_drain", 12, 4, exp4);

    // Reset while a candidate is pending and two entries are queued
    do_call(32'h500, 1);
    do_call(32'h600, 1);
    run_cycle(1, JAL, 32'h700, 32'h0, 0, 1);
    #2;
    reset = 1;
    #1;
    chk("rst_mid_jal", {31'd0, bus.monitor_jal_o}, 32'd0);
    chk("rst_mid_jr", {31'd0, bus.monitor_jr_o}, 32'd0);
    chk("rst_mid_addr", bus.monitor_address_o, 32'd0);
    chk("rst_mid_ovf", {31'd0, bus.overflow_o}, 32'd0);
    bus.insn_valid_i = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    bus.monitor_busy_i = 0;
    run_cycle(1, NOP, 32'h704, 32'h0, 0, 0);
    exp4 = '{32'h0, 32'h0, 32'h0, 32'h0};
    drain_check("rst_mid_drain", 10, 0, exp4);

    // Randomized traffic against the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      r    = $urandom();
      pick = int'($urandom_range(0, 5));
      case (pick)
        0:       insn = {6'h01, r[25:0]};
        1:       insn = {6'h12, r[25:0]};
        2:       insn = {6'h11, r[25:16], 5'd9, r[10:0]};
        3:       insn = {6'h11, r[25:16], r[15:11] ^ 5'd1, r[10:0]};
        default: insn = r;
      endcase
      pcv = $urandom();
      rbv = $urandom();
      run_cycle($urandom_range(0, 3) != 0, insn, pcv, rbv, $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) apply_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
